demux_1_4_2bits_buf: RTL and testbench

- 1-to-4 steering demultiplexer: the distribution counterpart of the 4-to-1 2-bit selector.
- A single valid/ready input stream carries a 2-bit word plus a 2-bit SEL tag; each accepted word is routed to output channel A/B/C/D.
- Each channel is buffered in a small FIFO with its own valid/ready, so one stalled consumer does not corrupt the others.
- Sits between a shared producer and four independent consumers.

---
 rtl/demux_1_4_2bits_buf_pkg.sv | 22 ++
 rtl/demux_1_4_2bits_buf_chan_fifo.sv | 64 ++++++
 rtl/demux_1_4_2bits_buf.sv | 69 ++++++
 tb/tb_demux_1_4_2bits_buf.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1_4_2bits_buf_pkg.sv
// Shared constants for the 1-to-4 steering demultiplexer and its channel FIFOs.
package demux_pkg;

   localparam int DEFAULT_WIDTH = 2;
   localparam int NUM_CH        = 4;

   typedef enum logic [1:0] {
      CH_A = 2'b00,
      CH_B = 2'b01,
      CH_C = 2'b10,
      CH_D = 2'b11
   } ch_sel_e;

   // One-hot write enable for the channel addressed by sel.
   function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] sel);
      logic [NUM_CH-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/demux_1_4_2bits_buf_chan_fifo.sv
// Single-clock FIFO for one output channel; occupancy counter kept apart from
// the wrapping read/write pointers so full and empty are unambiguous.
module chan_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic             do_push,  do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop  & ~empty;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset; emptiness is tracked by count_q and the top masks stale words.
   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/demux_1_4_2bits_buf.sv
// 1-to-4 steering demultiplexer: one valid/ready input stream routed by SEL
// into four independently back-pressured channel FIFOs.
module demux_1_4_2bits_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] IN,
   input  logic [1:0]       SEL,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] OUT_A,
   output logic [WIDTH-1:0] OUT_B,
   output logic [WIDTH-1:0] OUT_C,
   output logic [WIDTH-1:0] OUT_D,
   output logic             VALID_A,
   output logic             VALID_B,
   output logic             VALID_C,
   output logic             VALID_D,
   input  logic             READY_A,
   input  logic             READY_B,
   input  logic             READY_C,
   input  logic             READY_D,
   output logic             BUSY
);

   logic [NUM_CH-1:0] full_w;
   logic [NUM_CH-1:0] empty_w;
   logic [NUM_CH-1:0] push_w;
   logic [NUM_CH-1:0] pop_w;
   logic [WIDTH-1:0]  dout_w [NUM_CH];
   logic [WIDTH-1:0]  out_w  [NUM_CH];

   // IN_READY depends only on SEL and registered occupancy, never on READY_x.
   assign IN_READY = ~full_w[SEL];
   assign push_w   = sel_onehot(SEL) & {NUM_CH{IN_VALID & IN_READY}};
   assign pop_w    = {READY_D, READY_C, READY_B, READY_A};

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
      chan_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .CLK   (CLK),
         .RST   (RST),
         .push  (push_w[ch]),
         .din   (IN),
         .pop   (pop_w[ch]),
         .dout  (dout_w[ch]),
         .full  (full_w[ch]),
         .empty (empty_w[ch])
      );
      assign out_w[ch] = empty_w[ch] ? '0 : dout_w[ch];
   end

   assign OUT_A   = out_w[CH_A];
   assign OUT_B   = out_w[CH_B];
   assign OUT_C   = out_w[CH_C];
   assign OUT_D   = out_w[CH_D];
   assign VALID_A = ~empty_w[CH_A];
   assign VALID_B = ~empty_w[CH_B];
   assign VALID_C = ~empty_w[CH_C];
   assign VALID_D = ~empty_w[CH_D];
   assign BUSY    = ~&empty_w;

endmodule

// File: tb/tb_demux_1_4_2bits_buf.sv
// Directed self-checking bench for demux_1_4_2bits_buf (WIDTH=2, DEPTH=2).
module tb_demux_1_4_2bits_buf;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] in_data, sel;
   logic       in_valid, in_ready;
   logic [1:0] out_a, out_b, out_c, out_d;
   logic       valid_a, valid_b, valid_c, valid_d;
   logic       ready_a, ready_b, ready_c, ready_d;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   demux_1_4_2bits_buf #(.WIDTH(2), .DEPTH(2)) dut (
      .CLK      (clk),
      .RST      (rst),
      .IN       (in_data),
      .SEL      (sel),
      .IN_VALID (in_valid),
      .IN_READY (in_ready),
      .OUT_A    (out_a),
      .OUT_B    (out_b),
      .OUT_C    (out_c),
      .OUT_D    (out_d),
      .VALID_A  (valid_a),
      .VALID_B  (valid_b),
      .VALID_C  (valid_c),
      .VALID_D  (valid_d),
      .READY_A  (ready_a),
      .READY_B  (ready_b),
      .READY_C  (ready_c),
      .READY_D  (ready_d),
      .BUSY     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] d);
      in_valid = v;
      sel      = s;
      in_data  = d;
   endtask

   task automatic check_all_idle(input string tag);
      check({tag, "_valid"}, {valid_a, valid_b, valid_c, valid_d}, 4'b0000);
      check({tag, "_out"},   {out_a, out_b, out_c, out_d}, 8'h00);
      check({tag, "_busy"},  busy, 1'b0);
   endtask

   // Producer rule: a stalled word keeps its SEL/IN until accepted or withdrawn.
   logic       stall_prev = 1'b0;
   logic [1:0] sel_prev   = '0;
   logic [1:0] in_prev    = '0;
   always @(negedge clk) begin
      if (stall_prev && in_valid && !rst) begin
         check("hold_sel", sel, sel_prev);
         check("hold_in", in_data, in_prev);
      end
      stall_prev = in_valid && !in_ready && !rst;
      sel_prev   = sel;
      in_prev    = in_data;
   end

   logic [1:0] exp_q [$];

   initial begin
      int pushed;
      int received;
      int cycles;
      logic [1:0] cur;
      logic       accept, take;

      rst = 1'b1;
      drive(1'b0, 2'b00, 2'b00);
      {ready_a, ready_b, ready_c, ready_d} = 4'b1111;
      tick();
      tick();
      check_all_idle("por");
      check("por_in_ready", in_ready, 1'b1);
      rst = 1'b0;
      tick();

      // Routing: each word lands one cycle after acceptance on its channel.
      drive(1'b1, 2'b00, 2'b00);
      tick();
      check("route_a_valid", valid_a, 1'b1);
      check("route_a_out", out_a, 2'b00);
      drive(1'b1, 2'b01, 2'b01);
      tick();
      check("route_b", {valid_b, out_b}, 3'b1_01);
      check("route_a_drained", valid_a, 1'b0);
      drive(1'b1, 2'b10, 2'b10);
      tick();
      check("route_c", {valid_c, out_c}, 3'b1_10);
      check("route_b_drained", valid_b, 1'b0);
      drive(1'b1, 2'b11, 2'b11);
      tick();
      check("route_d", {valid_d, out_d}, 3'b1_11);
      check("route_busy", busy, 1'b1);
      drive(1'b0, 2'b11, 2'b00);
      tick();
      check_all_idle("route_end");

      // Full / backpressure on A; third word refused, SEL change reopens input.
      ready_a = 1'b0;
      drive(1'b1, 2'b00, 2'b01);
      tick();
      drive(1'b1, 2'b00, 2'b10);
      tick();
      drive(1'b1, 2'b00, 2'b11);
      #1;
      check("full_a_in_ready", in_ready, 1'b0);
      check("full_a_head", {valid_a, out_a}, 3'b1_01);
      tick();
      check("full_a_still_blocked", in_ready, 1'b0);
      drive(1'b0, 2'b01, 2'b11);
      #1;
      check("full_a_sel_b_ready", in_ready, 1'b1);
      ready_a = 1'b1;
      tick();
      check("full_a_second", {valid_a, out_a}, 3'b1_10);
      check("full_a_b_untouched", valid_b, 1'b0);
      tick();
      check("full_a_drained", valid_a, 1'b0);

      // Simultaneous push/pop on D holding occupancy at 1.
      drive(1'b1, 2'b11, 2'b00);
      tick();
      for (int k = 1; k <= 8; k++) begin
         in_data = 2'(k);
         #1;
         check("pp_d_in_ready", in_ready, 1'b1);
         check("pp_d_head", {valid_d, out_d}, {1'b1, 2'(k - 1)});
         tick();
      end
      drive(1'b0, 2'b11, 2'b00);
      check("pp_d_last", {valid_d, out_d}, {1'b1, 2'(8)});
      tick();
      check("pp_d_drained", valid_d, 1'b0);

      // Wrap-around on C with random consumer stalls, checked against a queue.
      pushed   = 0;
      received = 0;
      cycles   = 0;
      exp_q.delete();
      cur = 2'($urandom_range(0, 3));
      while ((pushed < 20 || received < 20) && cycles < 300) begin
         drive(pushed < 20, 2'b10, cur);
         ready_c = 1'($urandom_range(0, 1));
         #1;
         check("wrap_valid", valid_c, exp_q.size() > 0);
         check("wrap_in_ready", in_ready, exp_q.size() < 2);
         take   = ready_c && (exp_q.size() > 0);
         accept = in_valid && (exp_q.size() < 2);
         if (take) begin
            check("wrap_data", out_c, exp_q[0]);
            void'(exp_q.pop_front());
            received++;
         end
         if (accept) begin
            exp_q.push_back(cur);
            pushed++;
            cur = 2'($urandom_range(0, 3));
         end
         tick();
         cycles++;
      end
      check("wrap_pushed", pushed, 20);
      check("wrap_received", received, 20);
      drive(1'b0, 2'b10, 2'b00);
      ready_c = 1'b1;

      // Full C with a pop in the same cycle still refuses the new word.
      ready_c = 1'b0;
      drive(1'b1, 2'b10, 2'b01);
      tick();
      drive(1'b1, 2'b10, 2'b10);
      tick();
      drive(1'b1, 2'b10, 2'b11);
      ready_c = 1'b1;
      #1;
      check("nopass_in_ready", in_ready, 1'b0);
      check("nopass_head", out_c, 2'b01);
      tick();
      check("nopass_reopen", in_ready, 1'b1);
      check("nopass_second", {valid_c, out_c}, 3'b1_10);
      tick();
      drive(1'b0, 2'b10, 2'b00);
      check("nopass_third", {valid_c, out_c}, 3'b1_11);
      tick();
      check("nopass_drained", valid_c, 1'b0);

      // Asynchronous reset mid-stream: 2 words in A, 1 in C.
      ready_a = 1'b0;
      ready_c = 1'b0;
      drive(1'b1, 2'b00, 2'b01);
      tick();
      drive(1'b1, 2'b00, 2'b10);
      tick();
      drive(1'b1, 2'b10, 2'b11);
      tick();
      drive(1'b0, 2'b00, 2'b00);
      #1;
      check("pre_rst_full_a", in_ready, 1'b0);
      check("pre_rst_valid", {valid_a, valid_c}, 2'b11);
      rst = 1'b1;
      #1;
      check_all_idle("rst_async");
      check("rst_in_ready", in_ready, 1'b1);
      tick();
      rst = 1'b0;
      {ready_a, ready_b, ready_c, ready_d} = 4'b1111;
      drive(1'b1, 2'b01, 2'b10);
      tick();
      check("post_rst_b", {valid_b, out_b}, 3'b1_10);
      check("post_rst_a_empty", valid_a, 1'b0);
      drive(1'b0, 2'b01, 2'b00);
      tick();
      check_all_idle("post_rst_end");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
